cv32e40s_fencei_flush_responder: RTL and testbench
==================================================

Name: cv32e40s_fencei_flush_responder

Overview:
- System-side responder for the core's fence.i flush handshake (fencei_flush_req / fencei_flush_ack).
- On a flush request it drains the downstream write buffer, then walks and invalidates every instruction-cache/prefetch line.
- After the walk it returns a single-cycle acknowledge to the controller FSM.
- Sits outside the core, between the controller's flush request output and the instruction-side memory subsystem.

Parameters:
- NUM_LINES, 16, number of lines to invalidate; power of two, >= 2.
- LINE_IDX_W, $clog2(NUM_LINES), width of the line index; derived, not overridden.
- CNT_W, 16, width of the completed-flush counter.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- fencei_flush_req_i  input  1  flush request from controller; held high until ack seen
- fencei_flush_ack_o  output  1  single-cycle flush acknowledge
- wbuf_drain_o  output  1  requests the write buffer to drain
- wbuf_empty_i  input  1  write buffer has no pending writes
- inv_valid_o  output  1  line invalidate request valid
- inv_ready_i  input  1  cache accepts invalidate
- inv_idx_o  output  LINE_IDX_W  line index to invalidate
- busy_o  output  1  sequence in progress (any state except IDLE)
- flush_cnt_o  output  CNT_W  saturating count of completed flushes

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset, while rst is high at a rising edge: state=IDLE, idx=0, flush_cnt=0. All outputs are 0 from that edge on.
- Reset mid-operation aborts immediately: inv_valid_o drops even with no handshake, and no ack is issued.
- All outputs are Moore-decoded from registered state, idx and counter. There is no combinational input-to-output path.
- FSM states: IDLE, DRAIN, INVAL, ACK, DONE.
- IDLE:
  - fencei_flush_req_i=1 -> DRAIN.
- DRAIN:
  - wbuf_drain_o=1.
  - wbuf_empty_i=1 -> INVAL with idx=0. Minimum one cycle in DRAIN, even if the buffer is already empty.
  - Waits indefinitely; there is no timeout.
- INVAL:
  - inv_valid_o=1, inv_idx_o=idx.
  - valid and idx stay stable until inv_ready_i=1 (valid/ready rules).
  - On handshake with idx==NUM_LINES-1 -> ACK, idx=0.
  - On any other handshake, idx+1.
  - One invalidate per cycle while ready stays high.
- ACK:
  - fencei_flush_ack_o=1 for exactly this cycle.
  - flush_cnt += 1, saturating at all-ones (no wrap).
  - Unconditionally -> DONE.
- DONE:
  - Waits for fencei_flush_req_i=0, then -> IDLE.
  - A request still high here is never treated as a new flush.
- A new flush is accepted only from IDLE. Back-to-back flushes therefore need req low for at least one sampled cycle.
- Request dropped before ACK (protocol violation): ignored. The sequence completes and ack is still pulsed.
- wbuf_empty_i and inv_ready_i are don't-care outside DRAIN and INVAL respectively.
- Latency, with req sampled high at edge 0, wbuf empty, inv_ready_i tied high:
  - DRAIN in cycle 1.
  - INVAL in cycles 2..NUM_LINES+1.
  - ack in cycle NUM_LINES+2 (cycle 18 at the default).
  - Each stall cycle on wbuf_empty_i or inv_ready_i adds one cycle.
- Assertions:
  - ack is never high two consecutive cycles.
  - inv_idx_o is stable while inv_valid_o && !inv_ready_i.
  - Exactly NUM_LINES invalidate handshakes occur between a DRAIN exit and the following ACK.

Test Plan:
- Basic flush: NUM_LINES=16, wbuf_empty_i=1, inv_ready_i=1; req high at cycle 0 and dropped the cycle after ack -> idx 0..15 on consecutive cycles, ack only at cycle 18, flush_cnt_o=1, busy_o low again at cycle 20.
- Drain stall: wbuf_empty_i low for 5 cycles after DRAIN entry -> wbuf_drain_o high 6 cycles, no inv_valid_o before empty, ack at cycle 23.
- Invalidate backpressure: inv_ready_i toggled 1,0,1,0,... -> idx held during each low cycle, all 16 indices issued exactly once in order, ack after the 16th handshake.
- Sticky request: req held high 10 cycles past ack -> FSM stays in DONE, no second drain or ack. Then req low 1 cycle and high again -> second full flush, flush_cnt_o=2.
- Reset mid-walk: rst high when idx=7 -> next cycle inv_valid_o=0, busy_o=0, flush_cnt_o=0, no ack. Subsequent req restarts at idx 0.
- Counter saturation: CNT_W=2, run 5 flushes -> flush_cnt_o reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/cv32e40s_fencei_flush_responder.sv
// fence.i flush responder: drains the write buffer, walks every
// I-cache/prefetch line with an invalidate, then pulses a one-cycle ack.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   fencei_flush_req_i        flush request (held until ack seen)
//   fencei_flush_ack_o        single-cycle acknowledge
//   wbuf_drain_o/wbuf_empty_i write buffer drain request / empty status
//   inv_valid_o/inv_ready_i   line invalidate handshake
//   inv_idx_o                 line index being invalidated
//   busy_o                    sequence in progress
//   flush_cnt_o               saturating count of completed flushes
module cv32e40s_fencei_flush_responder #(
   parameter  int unsigned NUM_LINES  = 16,
   localparam int unsigned LINE_IDX_W = $clog2(NUM_LINES),
   parameter  int unsigned CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fencei_flush_req_i,
   output logic                  fencei_flush_ack_o,
   output logic                  wbuf_drain_o,
   input  logic                  wbuf_empty_i,
   output logic                  inv_valid_o,
   input  logic                  inv_ready_i,
   output logic [LINE_IDX_W-1:0] inv_idx_o,
   output logic                  busy_o,
   output logic [CNT_W-1:0]      flush_cnt_o
);

   typedef enum logic [2:0] {
      IDLE,
      DRAIN,
      INVAL,
      ACK,
      DONE
   } state_e;

   localparam logic [LINE_IDX_W-1:0] IDX_MAX =
      LINE_IDX_W'(NUM_LINES - 1);

   state_e                state_q, state_d;
   logic [LINE_IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d            = state_q;
      idx_d              = idx_q;
      cnt_d              = cnt_q;
      fencei_flush_ack_o = 1'b0;
      wbuf_drain_o       = 1'b0;
      inv_valid_o        = 1'b0;
      busy_o             = (state_q != IDLE);

      unique case (state_q)
         IDLE: begin
            if (fencei_flush_req_i) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            wbuf_drain_o = 1'b1;
            if (wbuf_empty_i) begin
               state_d = INVAL;
               idx_d   = '0;
            end
         end
         INVAL: begin
            inv_valid_o = 1'b1;
            if (inv_ready_i) begin
               if (idx_q == IDX_MAX) begin
                  state_d = ACK;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + LINE_IDX_W'(1);
               end
            end
         end
         ACK: begin
            fencei_flush_ack_o = 1'b1;
            state_d            = DONE;
            if (!(&cnt_q)) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            // A request still held from the last flush must not retrigger.
            if (!fencei_flush_req_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // idx_q is 0 everywhere outside INVAL, so it can drive the port directly.
   assign inv_idx_o   = idx_q;
   assign flush_cnt_o = cnt_q;

   a_ack_single : assert property (
      @(posedge clk) disable iff (rst)
      fencei_flush_ack_o |=> !fencei_flush_ack_o);

   a_idx_stable : assert property (
      @(posedge clk) disable iff (rst)
      (inv_valid_o && !inv_ready_i) |=>
         (inv_valid_o && $stable(inv_idx_o)));

   // idx starts at 0 on DRAIN exit and steps once per handshake, so
   // entering ACK only via the last-line handshake means exactly
   // NUM_LINES invalidates were accepted.
   a_ack_after_walk : assert property (
      @(posedge clk) disable iff (rst)
      (state_q == ACK) |->
         $past(state_q == INVAL && inv_ready_i && idx_q == IDX_MAX));

endmodule

// File: tb/tb_cv32e40s_fencei_flush_responder.sv
// Self-checking bench for cv32e40s_fencei_flush_responder.
// Two instances share stimulus: default counter width and a 2-bit counter.
module tb_cv32e40s_fencei_flush_responder;

   localparam int N = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req = 1'b0;
   logic       empty = 1'b1;
   logic       ready = 1'b1;

   logic        ack, drain, valid, busy;
   logic [3:0]  idx;
   logic [15:0] cnt;
   logic        ack2, drain2, valid2, busy2;
   logic [3:0]  idx2;
   logic [1:0]  cnt2;

   cv32e40s_fencei_flush_responder #(.NUM_LINES(N), .CNT_W(16)) dut (
      .clk                (clk),
      .rst                (rst),
      .fencei_flush_req_i (req),
      .fencei_flush_ack_o (ack),
      .wbuf_drain_o       (drain),
      .wbuf_empty_i       (empty),
      .inv_valid_o        (valid),
      .inv_ready_i        (ready),
      .inv_idx_o          (idx),
      .busy_o             (busy),
      .flush_cnt_o        (cnt)
   );

   cv32e40s_fencei_flush_responder #(.NUM_LINES(N), .CNT_W(2)) dut2 (
      .clk                (clk),
      .rst                (rst),
      .fencei_flush_req_i (req),
      .fencei_flush_ack_o (ack2),
      .wbuf_drain_o       (drain2),
      .wbuf_empty_i       (empty),
      .inv_valid_o        (valid2),
      .inv_ready_i        (ready),
      .inv_idx_o          (idx2),
      .busy_o             (busy2),
      .flush_cnt_o        (cnt2)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: where in the flush we are, tracked as flags
   // plus a count of lines already invalidated.
   bit m_seq, m_drained, m_ack, m_hold;
   int m_lines, m_done;

   int ecnt = 0;
   int ack_total = 0;
   int ack_ecnt = 0;
   int drain_cyc = 0;
   logic [3:0] hs_q[$];
   bit         pv = 1'b0;
   logic [3:0] pidx = '0;

   always @(posedge clk) begin
      #1;
      ecnt++;
      if (rst) begin
         m_seq = 0; m_drained = 0; m_ack = 0; m_hold = 0;
         m_lines = 0; m_done = 0;
      end else if (m_ack) begin
         m_ack = 0; m_hold = 1; m_done++;
      end else if (m_hold) begin
         if (!req) m_hold = 0;
      end else if (!m_seq) begin
         if (req) begin m_seq = 1; m_drained = 0; end
      end else if (!m_drained) begin
         if (empty) begin m_drained = 1; m_lines = 0; end
      end else if (ready) begin
         if (m_lines == N - 1) begin
            m_seq = 0; m_drained = 0; m_lines = 0; m_ack = 1;
         end else begin
            m_lines++;
         end
      end

      if (rst) hs_q.delete();
      else if (pv && ready) hs_q.push_back(pidx);
      pv   = valid;
      pidx = idx;

      chk("ack",   ack,   m_ack);
      chk("drain", drain, m_seq && !m_drained);
      chk("valid", valid, m_seq && m_drained);
      chk("busy",  busy,  m_seq || m_ack || m_hold);
      chk("cnt",   cnt,   (m_done > 65535) ? 65535 : m_done);
      chk("cnt2",  cnt2,  (m_done > 3) ? 3 : m_done);
      chk("ack2",  ack2,  ack);
      chk("valid2", valid2, valid);
      if (m_seq && m_drained) begin
         chk("idx",  idx,  m_lines);
         chk("idx2", idx2, idx);
      end

      if (ack) begin
         bit ok;
         ack_total++;
         ack_ecnt = ecnt;
         chk("hs_count", hs_q.size(), N);
         ok = (hs_q.size() == N);
         foreach (hs_q[i]) if (hs_q[i] != 4'(i)) ok = 0;
         chk("hs_order", ok, 1);
         hs_q.delete();
      end
      if (drain) drain_cyc++;
   end

   int e0, a0;

   task automatic reset_dut();
      @(negedge clk);
      rst = 1; req = 0; empty = 1; ready = 1;
      @(negedge clk);
      rst = 0;
   endtask

   task automatic start_req();
      @(negedge clk);
      req = 1;
      e0 = ecnt + 1;
      a0 = ack_total;
   endtask

   task automatic wait_ack(output int cyc);
      int k;
      for (k = 0; k < 200 && ack_total == a0; k++) @(negedge clk);
      if (ack_total == a0) begin
         chk("ack_timeout", 0, 1);
         cyc = -1;
      end else begin
         cyc = ack_ecnt - e0 + 1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, a1, d;
      int sat_exp[5] = '{1, 2, 3, 3, 3};

      repeat (3) @(negedge clk);
      chk("rst_busy",  busy, 0);
      chk("rst_valid", valid, 0);
      chk("rst_cnt",   cnt, 0);
      rst = 0;

      // basic flush
      reset_dut();
      start_req();
      wait_ack(c);
      chk("basic_ack_cyc", c, 18);
      req = 0;
      @(negedge clk);
      chk("basic_busy19", busy, 1);
      @(negedge clk);
      chk("basic_busy20", busy, 0);
      chk("basic_cnt", cnt, 1);
      chk("basic_acks", ack_total - a0, 1);

      // drain stall
      reset_dut();
      empty = 0;
      drain_cyc = 0;
      start_req();
      repeat (6) @(negedge clk);
      empty = 1;
      wait_ack(c);
      chk("stall_ack_cyc", c, 23);
      chk("stall_drain_cyc", drain_cyc, 6);
      req = 0;

      // invalidate backpressure
      reset_dut();
      start_req();
      c = 1;
      while (ack_total == a0 && c < 200) begin
         @(negedge clk);
         ready = (c % 2 == 0);
         c++;
      end
      chk("bp_ack_seen", ack_total - a0, 1);
      chk("bp_ack_cyc", ack_ecnt - e0 + 1, 33);
      req = 0;
      ready = 1;

      // sticky request
      reset_dut();
      start_req();
      wait_ack(c);
      a1 = ack_total;
      d = drain_cyc;
      repeat (11) @(negedge clk);
      chk("sticky_no_ack", ack_total, a1);
      chk("sticky_no_drain", drain_cyc, d);
      chk("sticky_busy", busy, 1);
      req = 0;
      @(negedge clk);
      req = 1;
      e0 = ecnt + 1;
      a0 = ack_total;
      wait_ack(c);
      chk("sticky_ack2_cyc", c, 18);
      @(negedge clk);
      chk("sticky_cnt", cnt, 2);
      req = 0;

      // reset mid-walk
      reset_dut();
      start_req();
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!(valid && idx == 4'd7) && c < 100);
      chk("mid_reach7", idx, 7);
      rst = 1;
      a1 = ack_total;
      @(negedge clk);
      chk("mid_valid", valid, 0);
      chk("mid_busy",  busy, 0);
      chk("mid_cnt",   cnt, 0);
      chk("mid_noack", ack_total, a1);
      rst = 0;
      req = 0;
      start_req();
      wait_ack(c);
      chk("mid_restart_cyc", c, 18);
      req = 0;

      // counter saturation
      reset_dut();
      for (int i = 0; i < 5; i++) begin
         start_req();
         wait_ack(c);
         req = 0;
         @(negedge clk);
         @(negedge clk);
         chk("sat_cnt2", cnt2, sat_exp[i]);
         chk("sat_cnt16", cnt, i + 1);
      end

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
